// File: rtl/vga_pkg.sv
// Shared constants and types for the tile text buffer and its maintenance engine.
package vga_pkg;

  localparam int H_TILES       = 80;
  localparam int V_TILES       = 30;
  localparam int WORDS_PER_ROW = H_TILES / 4;
  localparam int NUM_WORDS     = WORDS_PER_ROW * V_TILES;

  typedef enum logic [1:0] {
    OP_CLEAR  = 2'b00,
    OP_SCROLL = 2'b01,
    OP_FILL   = 2'b10,
    OP_RSVD   = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    FILL   = 3'd2,
    SCR_RD = 3'd3,
    SCR_WR = 3'd4,
    DONE   = 3'd5
  } state_e;

  // Four 7-bit characters per word, each in the low bits of its byte, top bit zero.
  function automatic logic [31:0] replicateChar(input logic [6:0] c);
    return {4{1'b0, c}};
  endfunction

endpackage

// File: rtl/scroll_ctrl.sv
// Text-buffer maintenance engine: clear-all, fill-row and scroll-up over a
// word-packed tile buffer, passing host writes straight through while idle.
module scroll_ctrl #(
  parameter int H_TILES     = 80,
  parameter int V_TILES     = 30,
  parameter int WORD_ADDR_W = 10
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   cmd_valid_i,
  output logic                   cmd_ready_o,
  input  logic [1:0]             cmd_op_i,
  input  logic [4:0]             cmd_row_i,
  input  logic [6:0]             cmd_char_i,
  input  logic                   host_wr_en_i,
  input  logic [WORD_ADDR_W-1:0] host_addr_i,
  input  logic [3:0]             host_strb_i,
  input  logic [31:0]            host_data_i,
  output logic                   host_wr_ready_o,
  output logic                   buf_wr_en_o,
  output logic [WORD_ADDR_W-1:0] buf_w_addr_o,
  output logic [3:0]             buf_w_strb_o,
  output logic [31:0]            buf_din_o,
  output logic                   buf_r_req_o,
  output logic [WORD_ADDR_W-1:0] buf_r_addr_o,
  input  logic [31:0]            buf_r_data_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   err_o
);

  import vga_pkg::*;

  localparam int WPR    = H_TILES / 4;
  localparam int NWORDS = WPR * V_TILES;

  localparam logic [WORD_ADDR_W-1:0] ONE           = WORD_ADDR_W'(1);
  localparam logic [WORD_ADDR_W-1:0] LAST_WORD     = WORD_ADDR_W'(NWORDS - 1);
  localparam logic [WORD_ADDR_W-1:0] SCR_LAST      = WORD_ADDR_W'(NWORDS - WPR - 1);
  localparam logic [WORD_ADDR_W-1:0] LAST_ROW_BASE = WORD_ADDR_W'(NWORDS - WPR);
  localparam logic [WORD_ADDR_W-1:0] ROW_SPAN      = WORD_ADDR_W'(WPR - 1);
  localparam logic [WORD_ADDR_W-1:0] SRC_OFS       = WORD_ADDR_W'(WPR);
  localparam logic [WORD_ADDR_W-1:0] NEXT_SRC_OFS  = WORD_ADDR_W'(WPR + 1);

  state_e                 state_q, state_d;
  logic [WORD_ADDR_W-1:0] cnt_q, cnt_d;
  logic [WORD_ADDR_W-1:0] last_q, last_d;
  logic [6:0]             char_q, char_d;
  logic                   errFlag_q, errFlag_d;

  logic                   bufWrEn_q, bufWrEn_d;
  logic [WORD_ADDR_W-1:0] bufWAddr_q, bufWAddr_d;
  logic [3:0]             bufWStrb_q, bufWStrb_d;
  logic [31:0]            bufDin_q, bufDin_d;
  logic                   bufRReq_q, bufRReq_d;
  logic [WORD_ADDR_W-1:0] bufRAddr_q, bufRAddr_d;

  logic [WORD_ADDR_W-1:0] rowBase;
  logic                   rowBad;
  logic                   cmdAccept;
  logic [31:0]            fillWord;

  assign rowBase   = WORD_ADDR_W'(int'(cmd_row_i) * WPR);
  assign rowBad    = int'(cmd_row_i) >= V_TILES;
  assign fillWord  = replicateChar(char_q);
  assign cmdAccept = cmd_valid_i && cmd_ready_o;

  assign host_wr_ready_o = (state_q == IDLE);
  assign cmd_ready_o     = (state_q == IDLE) && !host_wr_en_i;
  assign busy_o          = (state_q != IDLE);
  assign done_o          = (state_q == DONE) && !errFlag_q;
  assign err_o           = (state_q == DONE) && errFlag_q;

  assign buf_wr_en_o  = bufWrEn_q;
  assign buf_w_addr_o = bufWAddr_q;
  assign buf_w_strb_o = bufWStrb_q;
  assign buf_din_o    = bufDin_q;
  assign buf_r_req_o  = bufRReq_q;
  assign buf_r_addr_o = bufRAddr_q;

  // State, counter, latched command and the registered buffer port.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      last_q     <= '0;
      char_q     <= '0;
      errFlag_q  <= 1'b0;
      bufWrEn_q  <= 1'b0;
      bufWAddr_q <= '0;
      bufWStrb_q <= '0;
      bufDin_q   <= '0;
      bufRReq_q  <= 1'b0;
      bufRAddr_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      char_q     <= char_d;
      errFlag_q  <= errFlag_d;
      bufWrEn_q  <= bufWrEn_d;
      bufWAddr_q <= bufWAddr_d;
      bufWStrb_q <= bufWStrb_d;
      bufDin_q   <= bufDin_d;
      bufRReq_q  <= bufRReq_d;
      bufRAddr_q <= bufRAddr_d;
    end
  end

  // Next-state and buffer-port decisions. Scroll reads are decided one cycle
  // ahead, so the request sits on the port during SCR_RD and its data is
  // already valid when SCR_WR decides the matching write.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_d     = last_q;
    char_d     = char_q;
    errFlag_d  = errFlag_q;
    bufWrEn_d  = 1'b0;
    bufWAddr_d = bufWAddr_q;
    bufWStrb_d = bufWStrb_q;
    bufDin_d   = bufDin_q;
    bufRReq_d  = 1'b0;
    bufRAddr_d = bufRAddr_q;

    case (state_q)
      IDLE: begin
        if (host_wr_en_i) begin
          bufWrEn_d  = 1'b1;
          bufWAddr_d = host_addr_i;
          bufWStrb_d = host_strb_i;
          bufDin_d   = host_data_i;
        end else if (cmdAccept) begin
          char_d    = cmd_char_i;
          errFlag_d = 1'b0;
          cnt_d     = '0;
          case (op_e'(cmd_op_i))
            OP_CLEAR: begin
              last_d  = LAST_WORD;
              state_d = CLEAR;
            end
            OP_SCROLL: begin
              last_d     = LAST_WORD;
              bufRReq_d  = 1'b1;
              bufRAddr_d = SRC_OFS;
              state_d    = SCR_RD;
            end
            OP_FILL: begin
              if (rowBad) begin
                errFlag_d = 1'b1;
                state_d   = DONE;
              end else begin
                cnt_d   = rowBase;
                last_d  = rowBase + ROW_SPAN;
                state_d = FILL;
              end
            end
            default: begin
              errFlag_d = 1'b1;
              state_d   = DONE;
            end
          endcase
        end
      end
      CLEAR, FILL: begin
        bufWrEn_d  = 1'b1;
        bufWAddr_d = cnt_q;
        bufWStrb_d = 4'hF;
        bufDin_d   = fillWord;
        if (cnt_q == last_q) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      SCR_RD: begin
        state_d = SCR_WR;
      end
      SCR_WR: begin
        bufWrEn_d  = 1'b1;
        bufWAddr_d = cnt_q;
        bufWStrb_d = 4'hF;
        bufDin_d   = buf_r_data_i;
        if (cnt_q == SCR_LAST) begin
          cnt_d   = LAST_ROW_BASE;
          last_d  = LAST_WORD;
          state_d = FILL;
        end else begin
          cnt_d      = cnt_q + ONE;
          bufRReq_d  = 1'b1;
          bufRAddr_d = cnt_q + NEXT_SRC_OFS;
          state_d    = SCR_RD;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_scroll_ctrl.sv
// Directed bench for scroll_ctrl with a behavioural model of the tile buffer.
module tb_scroll_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        cmd_valid_i = 1'b0;
  logic        cmd_ready_o;
  logic [1:0]  cmd_op_i = 2'b00;
  logic [4:0]  cmd_row_i = 5'd0;
  logic [6:0]  cmd_char_i = 7'd0;
  logic        host_wr_en_i = 1'b0;
  logic [9:0]  host_addr_i = 10'd0;
  logic [3:0]  host_strb_i = 4'd0;
  logic [31:0] host_data_i = 32'd0;
  logic        host_wr_ready_o;
  logic        buf_wr_en_o;
  logic [9:0]  buf_w_addr_o;
  logic [3:0]  buf_w_strb_o;
  logic [31:0] buf_din_o;
  logic        buf_r_req_o;
  logic [9:0]  buf_r_addr_o;
  logic [31:0] buf_r_data_i;
  logic        busy_o;
  logic        done_o;
  logic        err_o;

  int total = 0;
  int bad = 0;

  scroll_ctrl #(.H_TILES(80), .V_TILES(30), .WORD_ADDR_W(10)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_op_i(cmd_op_i),
    .cmd_row_i(cmd_row_i), .cmd_char_i(cmd_char_i),
    .host_wr_en_i(host_wr_en_i), .host_addr_i(host_addr_i), .host_strb_i(host_strb_i),
    .host_data_i(host_data_i), .host_wr_ready_o(host_wr_ready_o),
    .buf_wr_en_o(buf_wr_en_o), .buf_w_addr_o(buf_w_addr_o), .buf_w_strb_o(buf_w_strb_o),
    .buf_din_o(buf_din_o), .buf_r_req_o(buf_r_req_o), .buf_r_addr_o(buf_r_addr_o),
    .buf_r_data_i(buf_r_data_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  // 25 MHz clock.
  initial forever #20 clk_i = ~clk_i;

  // Synchronous buffer model: byte-strobed writes, read data one cycle after request.
  logic [31:0] mem [0:1023];
  int          wrLog[$];
  int          doneCount = 0;
  int          errCount = 0;
  int          rdCount = 0;

  always @(posedge clk_i) begin
    if (buf_wr_en_o) begin
      for (int b = 0; b < 4; b++)
        if (buf_w_strb_o[b]) mem[buf_w_addr_o][8*b +: 8] <= buf_din_o[8*b +: 8];
      wrLog.push_back(int'(buf_w_addr_o));
    end
    if (buf_r_req_o) begin
      buf_r_data_i <= mem[buf_r_addr_o];
      rdCount++;
    end
    if (done_o) doneCount++;
    if (err_o) errCount++;
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Present a command and return #1 after its acceptance edge; the inputs are
  // scrambled afterwards so any failure to latch them shows up.
  task automatic applyStimulus(input logic [1:0] op, input logic [4:0] row, input logic [6:0] ch);
    int waited = 0;
    while (!cmd_ready_o && waited < 20) begin
      step();
      waited++;
    end
    checkOutput("cmd_ready_before_issue", cmd_ready_o, 1'b1);
    cmd_op_i    = op;
    cmd_row_i   = row;
    cmd_char_i  = ch;
    cmd_valid_i = 1'b1;
    step();
    cmd_valid_i = 1'b0;
    cmd_op_i    = 2'b11;
    cmd_row_i   = 5'd0;
    cmd_char_i  = 7'h7F;
  endtask

  // Cycle n=1 is the first cycle after the acceptance edge.
  task automatic waitEnd(input int maxCyc, output int endCyc, output int busyCyc, output logic gotErr);
    endCyc  = 0;
    busyCyc = 0;
    gotErr  = 1'b0;
    for (int n = 1; n <= maxCyc; n++) begin
      if (done_o || err_o) begin
        endCyc = n;
        gotErr = err_o;
        break;
      end
      if (busy_o) busyCyc++;
      step();
    end
    if (endCyc == 0) checkOutput("end_timeout", 32'd1, 32'd0);
  endtask

  task automatic hostPreload();
    for (int w = 0; w < 600; w++) begin
      host_wr_en_i = 1'b1;
      host_addr_i  = 10'(w);
      host_strb_i  = 4'hF;
      host_data_i  = 32'(w);
      step();
    end
    host_wr_en_i = 1'b0;
    step();
    step();
  endtask

  initial begin : watchdog
    #(40 * 60000);
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin : main
    int endCyc, busyCyc, mism, logStart, d0, e0, r0;
    logic gotErr;
    logic found;

    // Reset state.
    repeat (3) step();
    checkOutput("rst_wr_en", buf_wr_en_o, 1'b0);
    checkOutput("rst_r_req", buf_r_req_o, 1'b0);
    checkOutput("rst_status", {busy_o, done_o, err_o}, 3'b000);
    checkOutput("rst_w_addr", buf_w_addr_o, 10'd0);
    checkOutput("rst_strb_din", {buf_w_strb_o, buf_din_o} == 36'd0, 1'b1);
    checkOutput("rst_r_addr", buf_r_addr_o, 10'd0);
    rst_i = 1'b0;
    step();
    checkOutput("idle_host_ready", host_wr_ready_o, 1'b1);
    checkOutput("idle_cmd_ready", cmd_ready_o, 1'b1);

    // Clear-all with space: done in cycle 602 counting acceptance as cycle 1.
    logStart = wrLog.size();
    d0 = doneCount;
    applyStimulus(2'b00, 5'd0, 7'h20);
    checkOutput("clear_busy_start", busy_o, 1'b1);
    waitEnd(700, endCyc, busyCyc, gotErr);
    checkOutput("clear_done_cycle", endCyc + 1, 602);
    checkOutput("clear_busy_cycles", busyCyc, 600);
    checkOutput("clear_not_err", gotErr, 1'b0);
    checkOutput("clear_busy_in_done", busy_o, 1'b1);
    step();
    checkOutput("clear_done_pulse", {done_o, busy_o}, 2'b00);
    checkOutput("clear_write_count", wrLog.size() - logStart, 600);
    mism = 0;
    for (int i = 0; i < 600; i++) begin
      if (wrLog[logStart + i] != i) mism++;
      if (mem[i] !== 32'h20202020) mism++;
    end
    checkOutput("clear_order_data", mism, 0);
    checkOutput("clear_done_count", doneCount - d0, 1);

    // Fill row 29 with 'A'.
    logStart = wrLog.size();
    applyStimulus(2'b10, 5'd29, 7'h41);
    waitEnd(100, endCyc, busyCyc, gotErr);
    checkOutput("fill29_done_cycle", endCyc, 21);
    checkOutput("fill29_not_err", gotErr, 1'b0);
    step();
    checkOutput("fill29_write_count", wrLog.size() - logStart, 20);
    mism = 0;
    for (int i = 0; i < 20; i++)
      if (wrLog[logStart + i] != 580 + i) mism++;
    for (int i = 0; i < 600; i++)
      if (mem[i] !== ((i >= 580) ? 32'h41414141 : 32'h20202020)) mism++;
    checkOutput("fill29_order_data", mism, 0);

    // Host write and command together: host wins, command goes next cycle.
    host_wr_en_i = 1'b1;
    host_addr_i  = 10'd5;
    host_strb_i  = 4'b0101;
    host_data_i  = 32'hA1B2C3D4;
    cmd_op_i     = 2'b10;
    cmd_row_i    = 5'd1;
    cmd_char_i   = 7'h42;
    cmd_valid_i  = 1'b1;
    #1;
    checkOutput("prio_cmd_ready", cmd_ready_o, 1'b0);
    checkOutput("prio_host_ready", host_wr_ready_o, 1'b1);
    step();
    checkOutput("prio_host_port", {buf_wr_en_o, buf_w_addr_o, buf_w_strb_o}, {1'b1, 10'd5, 4'b0101});
    checkOutput("prio_host_din", buf_din_o, 32'hA1B2C3D4);
    checkOutput("prio_not_busy", busy_o, 1'b0);
    host_wr_en_i = 1'b0;
    #1;
    checkOutput("prio_cmd_ready_next", cmd_ready_o, 1'b1);
    step();
    cmd_valid_i = 1'b0;
    checkOutput("prio_cmd_accepted", busy_o, 1'b1);
    waitEnd(100, endCyc, busyCyc, gotErr);
    checkOutput("prio_fill_done_cycle", endCyc, 21);
    step();
    checkOutput("prio_host_merge", mem[5], 32'h20B220D4);
    checkOutput("prio_fill_row1", {mem[20], mem[39]}, {32'h42424242, 32'h42424242});
    checkOutput("prio_row2_untouched", mem[40], 32'h20202020);

    // Scroll-up over a buffer holding word index in each word.
    hostPreload();
    logStart = wrLog.size();
    r0 = rdCount;
    applyStimulus(2'b01, 5'd0, 7'h2E);
    waitEnd(1300, endCyc, busyCyc, gotErr);
    checkOutput("scroll_active_cycles", busyCyc, 1180);
    checkOutput("scroll_done_cycle", endCyc, 1181);
    checkOutput("scroll_not_err", gotErr, 1'b0);
    step();
    checkOutput("scroll_write_count", wrLog.size() - logStart, 600);
    checkOutput("scroll_read_count", rdCount - r0, 580);
    mism = 0;
    for (int i = 0; i < 600; i++) begin
      if (wrLog[logStart + i] != i) mism++;
      if (mem[i] !== ((i < 580) ? 32'(i + 20) : 32'h2E2E2E2E)) mism++;
    end
    checkOutput("scroll_order_data", mism, 0);

    // Rejected commands: fill-row 30 and the reserved op.
    logStart = wrLog.size();
    e0 = errCount;
    d0 = doneCount;
    applyStimulus(2'b10, 5'd30, 7'h33);
    checkOutput("err_row30_pulse", {err_o, done_o, busy_o}, 3'b101);
    step();
    checkOutput("err_row30_idle", {err_o, busy_o, cmd_ready_o}, 3'b001);
    applyStimulus(2'b11, 5'd3, 7'h33);
    checkOutput("err_op11_pulse", {err_o, done_o, busy_o}, 3'b101);
    repeat (3) step();
    checkOutput("err_no_writes", wrLog.size() - logStart, 0);
    checkOutput("err_counts", {errCount - e0, doneCount - d0}, {32'd2, 32'd0});

    // Reset while clear-all is writing word 300.
    logStart = wrLog.size();
    d0 = doneCount;
    applyStimulus(2'b00, 5'd0, 7'h55);
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      if (buf_wr_en_o && buf_w_addr_o == 10'd300) found = 1'b1;
      else step();
    end
    checkOutput("rstmid_reached_300", found, 1'b1);
    rst_i = 1'b1;
    step();
    checkOutput("rstmid_outputs", {buf_wr_en_o, buf_r_req_o, busy_o, done_o, err_o}, 5'd0);
    checkOutput("rstmid_addr_din", {buf_w_addr_o, buf_w_strb_o, buf_din_o, buf_r_addr_o} == 56'd0, 1'b1);
    checkOutput("rstmid_host_ready", host_wr_ready_o, 1'b1);
    rst_i = 1'b0;
    repeat (400) step();
    checkOutput("rstmid_no_done", doneCount - d0, 0);
    checkOutput("rstmid_write_count", wrLog.size() - logStart, 301);
    checkOutput("rstmid_partial", {mem[300], mem[301]}, {32'h55555555, 32'd321});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
